pkt_collector_mc: RTL
=====================

// Module: pkt_collector_mc
// PURPOSE
//  Multi-channel successor to the single-word packet collector. Accepts 48-bit
//  {app,size,seq,data} words on a valid/ready input and reassembles multi-packet
//  messages in one slot per application. Emits each completed message, up to
//  MAX_PKTS*DATA_W bits, on a registered valid/ready output.
//  Sits between the link deserialiser and the per-application compute units.
//  Reports bad size, sequence break and per-slot timeout as error pulses.
// PARAMETERS
//  DATA_W   40  payload bits per packet
//  APP_W    2   application field width; app 0 = idle/null, always ignored
//  SIZE_W   3   size field width; size = packets in message, legal 1..MAX_PKTS
//  SEQ_W    3   packet index field width, 0-based, first packet seq=0
//  NUM_APPS 3   slots for app codes 1..NUM_APPS; codes above NUM_APPS are ignored
//  MAX_PKTS 4   maximum packets per message (<= 2**SEQ_W)
//  TIMEOUT  255 idle cycles before a partial slot is aborted; 0 = disabled
// PORTS
//  clk        in   1                        rising-edge clock
//  rstn       in   1                        async active-low reset
//  in_valid   in   1                        input word valid
//  in_ready   out  1                        input word accepted when in_valid & in_ready
//  datain     in   APP_W+SIZE_W+SEQ_W+DATA_W  {app,size,seq,data}, MSB first
//  out_valid  out  1                        completed message valid
//  out_ready  in   1                        downstream accepts message
//  out_app    out  APP_W                    application code of message
//  out_size   out  SIZE_W                   packets in message
//  out_data   out  MAX_PKTS*DATA_W          message, right-justified, packet 0 most significant
//  err_pulse  out  1                        one-cycle error strobe
//  err_code   out  2                        01 bad size, 10 seq break, 11 timeout; held until next error
//  err_app    out  APP_W                    slot that raised the error
// BEHAVIOUR
//  - Reset (async, rstn=0): every slot IDLE with data, count and timer cleared; all outputs 0.
//    in_ready=0 during reset only. Reset mid-message discards all partial and complete data.
//  - Slot states: IDLE -> ASM (seq 0 accepted, size>1) -> DONE (last seq accepted) -> IDLE (message loaded to output).
//    A size=1, seq=0 packet goes from IDLE straight to DONE.
//  - in_ready = !(addressed slot DONE). It is combinational on the app field of datain; null and ignored apps always see ready=1.
//  - An accepted word with app 0 or app>NUM_APPS is dropped silently. No error is raised.
//  - Bad size (0 or >MAX_PKTS): word dropped, slot untouched, err 01.
//  - Accept in IDLE: seq must be 0, else drop with err 10.
//  - Accept in ASM: seq must equal count and size must match the latched size.
//    On mismatch the partial is discarded and err 10 is raised. If the offending word has seq=0
//    and legal size, it restarts the slot in the same cycle.
//  - Packing: packet k is written to bits [(size-1-k)*DATA_W +: DATA_W]. Bits above size*DATA_W are 0.
//  - Timeout: each ASM slot has a counter reset on every accepted word for that slot.
//    When it reaches TIMEOUT, the slot goes to IDLE and err 11 is raised. An accept and a timeout in
//    the same cycle: the accept wins, no timeout. IDLE and DONE slots do not time out.
//  - Errors from a rejected input and a timeout in the same cycle: the input error is reported and the
//    timeout is deferred one cycle. err_pulse never covers two events.
//  - Output stage: a registered holding register. It loads when (!out_valid | out_ready) and any slot is
//    DONE. The slot is chosen round-robin, starting after the last granted app; the chosen slot returns to IDLE.
//  - Latency: last word accepted at cycle N gives DONE at N+1 and out_valid at N+2 if the holding register is
//    free. Back-to-back messages are possible at one per cycle with out_ready=1.
//  - out_* are stable while out_valid & !out_ready. A slot that is DONE may not start a new message until it is granted.
// TESTING
//  - app=1,size=1,seq=0,data=40'hAB_CDEF_0123 -> 2 cycles later out_valid, out_app=1, out_size=1, out_data low 40b = 40'hAB_CDEF_0123, upper 120b = 0.
//  - app=2,size=2: seq0 data=A, seq1 data=B -> out_data[79:40]=A, [39:0]=B; err_pulse never asserts.
//  - Interleave app1 (size 3) and app3 (size 2) words with out_ready=1 -> both messages intact; app3 emitted first (completes first).
//  - app=1,size=3: seq0, then seq2 -> err_pulse, err_code=10, err_app=1, slot IDLE. A following seq1 is dropped with err 10.
//  - size=5 (MAX_PKTS=4) -> err_code=01, no state change. app=0 word -> dropped silently, in_ready=1.
//  - app=2 seq0 of size 2, then idle TIMEOUT cycles -> err 11 exactly TIMEOUT cycles after the accept.
//    out_ready=0 with app1 DONE -> a new app1 word sees in_ready=0; after out_ready=1 it is accepted. Assert rstn=0 mid-message -> all outputs 0.

Source files
------------

// File: rtl/pkt_collector_mc.sv
// Multi-channel packet collector: rebuilds {app,size,seq,data} words into one
// message per application slot and hands completed messages out round-robin.
module pkt_collector_mc #(
    parameter int unsigned DATA_W   = 40,
    parameter int unsigned APP_W    = 2,
    parameter int unsigned SIZE_W   = 3,
    parameter int unsigned SEQ_W    = 3,
    parameter int unsigned NUM_APPS = 3,
    parameter int unsigned MAX_PKTS = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [APP_W+SIZE_W+SEQ_W+DATA_W-1:0] datain,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [APP_W-1:0]                     out_app,
    output logic [SIZE_W-1:0]                    out_size,
    output logic [MAX_PKTS*DATA_W-1:0]           out_data,
    output logic                                 err_pulse,
    output logic [1:0]                           err_code,
    output logic [APP_W-1:0]                     err_app
);

    localparam int unsigned MSG_W = MAX_PKTS * DATA_W;
    localparam int unsigned IDX_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ASM  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] E_SIZE = 2'b01;
    localparam logic [1:0] E_SEQ  = 2'b10;
    localparam logic [1:0] E_TMO  = 2'b11;

    // Per-slot state
    logic [1:0]        st_q   [NUM_APPS];
    logic [1:0]        st_d   [NUM_APPS];
    logic [SIZE_W-1:0] sz_q   [NUM_APPS];
    logic [SIZE_W-1:0] sz_d   [NUM_APPS];
    logic [SIZE_W-1:0] cnt_q  [NUM_APPS];
    logic [SIZE_W-1:0] cnt_d  [NUM_APPS];
    logic [TMR_W-1:0]  tmr_q  [NUM_APPS];
    logic [TMR_W-1:0]  tmr_d  [NUM_APPS];
    logic [MSG_W-1:0]  buf_q  [NUM_APPS];
    logic [MSG_W-1:0]  buf_d  [NUM_APPS];
    logic [NUM_APPS-1:0] pend_q, pend_d;

    // Output holding register and error reporting
    logic              ov_q, ov_d;
    logic [APP_W-1:0]  oapp_q, oapp_d;
    logic [SIZE_W-1:0] osize_q, osize_d;
    logic [MSG_W-1:0]  odata_q, odata_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              ep_q, ep_d;
    logic [1:0]        ec_q, ec_d;
    logic [APP_W-1:0]  ea_q, ea_d;

    logic [APP_W-1:0]    w_app;
    logic [SIZE_W-1:0]   w_size;
    logic [SEQ_W-1:0]    w_seq;
    logic [DATA_W-1:0]   w_data;
    logic                size_ok_c;
    logic                slot_busy_c;
    logic                acc_c;
    logic [NUM_APPS-1:0] hit_c;
    logic [MSG_W-1:0]    pkt_c;
    int                  lane_c;
    logic                in_err_c;
    logic [1:0]          in_code_c;
    logic                tfound_c;
    logic                gfound_c;
    int                  gidx_c;
    int                  cidx_c;

    assign {w_app, w_size, w_seq, w_data} = datain;
    assign size_ok_c = (w_size != '0) && (32'(w_size) <= MAX_PKTS);

    // Ready drops only while the addressed slot holds an ungranted message
    always_comb begin
        slot_busy_c = 1'b0;
        for (int s = 0; s < int'(NUM_APPS); s++) begin
            if (w_app == APP_W'(s + 1) && st_q[s] == S_DONE) begin
                slot_busy_c = 1'b1;
            end
        end
    end

    assign in_ready = rstn & ~slot_busy_c;
    assign acc_c    = in_valid & in_ready;

    always_comb begin
        hit_c = '0;
        for (int s = 0; s < int'(NUM_APPS); s++) begin
            hit_c[s] = acc_c && (w_app == APP_W'(s + 1));
        end
    end

    // Incoming payload placed in its lane; packet 0 ends up most significant
    always_comb begin
        pkt_c  = '0;
        lane_c = int'(w_size) - 1 - int'(w_seq);
        for (int k = 0; k < int'(MAX_PKTS); k++) begin
            if (lane_c == k) begin
                pkt_c[k*DATA_W +: DATA_W] = w_data;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < int'(NUM_APPS); s++) begin
            st_d[s]  = st_q[s];
            sz_d[s]  = sz_q[s];
            cnt_d[s] = cnt_q[s];
            tmr_d[s] = tmr_q[s];
            buf_d[s] = buf_q[s];
        end
        pend_d    = pend_q;
        ov_d      = ov_q;
        oapp_d    = oapp_q;
        osize_d   = osize_q;
        odata_d   = odata_q;
        last_d    = last_q;
        ep_d      = 1'b0;
        ec_d      = ec_q;
        ea_d      = ea_q;
        in_err_c  = 1'b0;
        in_code_c = '0;
        tfound_c  = 1'b0;
        gfound_c  = 1'b0;
        gidx_c    = 0;
        cidx_c    = 0;

        for (int s = 0; s < int'(NUM_APPS); s++) begin
            if (hit_c[s]) begin
                tmr_d[s] = '0;
                if (!size_ok_c) begin
                    in_err_c  = 1'b1;
                    in_code_c = E_SIZE;
                end else if (st_q[s] == S_ASM && 32'(w_seq) == 32'(cnt_q[s])
                             && w_size == sz_q[s]) begin
                    buf_d[s] = buf_q[s] | pkt_c;
                    cnt_d[s] = cnt_q[s] + SIZE_W'(1);
                    if (cnt_q[s] + SIZE_W'(1) == sz_q[s]) begin
                        st_d[s] = S_DONE;
                    end
                end else if (w_seq == '0) begin
                    // A seq-0 word mid-message aborts the partial and restarts
                    if (st_q[s] == S_ASM) begin
                        in_err_c  = 1'b1;
                        in_code_c = E_SEQ;
                    end
                    buf_d[s] = pkt_c;
                    sz_d[s]  = w_size;
                    cnt_d[s] = SIZE_W'(1);
                    st_d[s]  = (w_size == SIZE_W'(1)) ? S_DONE : S_ASM;
                end else begin
                    in_err_c  = 1'b1;
                    in_code_c = E_SEQ;
                    st_d[s]   = S_IDLE;
                    cnt_d[s]  = '0;
                    buf_d[s]  = '0;
                end
            end else if (TIMEOUT != 0 && st_q[s] == S_ASM) begin
                if (tmr_q[s] == TMR_W'(TIMEOUT - 1)) begin
                    st_d[s]   = S_IDLE;
                    cnt_d[s]  = '0;
                    buf_d[s]  = '0;
                    tmr_d[s]  = '0;
                    pend_d[s] = 1'b1;
                end else begin
                    tmr_d[s] = tmr_q[s] + TMR_W'(1);
                end
            end
        end

        // Input errors take the strobe; timeouts wait in pend until it is free
        if (in_err_c) begin
            ep_d = 1'b1;
            ec_d = in_code_c;
            ea_d = w_app;
        end else begin
            for (int s = 0; s < int'(NUM_APPS); s++) begin
                if (!tfound_c && pend_d[s]) begin
                    tfound_c  = 1'b1;
                    pend_d[s] = 1'b0;
                    ep_d      = 1'b1;
                    ec_d      = E_TMO;
                    ea_d      = APP_W'(s + 1);
                end
            end
        end

        if (!ov_q || out_ready) begin
            ov_d = 1'b0;
            for (int i = 1; i <= int'(NUM_APPS); i++) begin
                cidx_c = int'(last_q) + i;
                if (cidx_c >= int'(NUM_APPS)) begin
                    cidx_c = cidx_c - int'(NUM_APPS);
                end
                if (!gfound_c && st_q[cidx_c] == S_DONE) begin
                    gfound_c = 1'b1;
                    gidx_c   = cidx_c;
                end
            end
            if (gfound_c) begin
                ov_d          = 1'b1;
                oapp_d        = APP_W'(gidx_c + 1);
                osize_d       = sz_q[gidx_c];
                odata_d       = buf_q[gidx_c];
                last_d        = IDX_W'(gidx_c);
                st_d[gidx_c]  = S_IDLE;
                cnt_d[gidx_c] = '0;
                buf_d[gidx_c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < int'(NUM_APPS); s++) begin
                st_q[s]  <= S_IDLE;
                sz_q[s]  <= '0;
                cnt_q[s] <= '0;
                tmr_q[s] <= '0;
                buf_q[s] <= '0;
            end
            pend_q  <= '0;
            ov_q    <= 1'b0;
            oapp_q  <= '0;
            osize_q <= '0;
            odata_q <= '0;
            last_q  <= IDX_W'(NUM_APPS - 1);
            ep_q    <= 1'b0;
            ec_q    <= '0;
            ea_q    <= '0;
        end else begin
            for (int s = 0; s < int'(NUM_APPS); s++) begin
                st_q[s]  <= st_d[s];
                sz_q[s]  <= sz_d[s];
                cnt_q[s] <= cnt_d[s];
                tmr_q[s] <= tmr_d[s];
                buf_q[s] <= buf_d[s];
            end
            pend_q  <= pend_d;
            ov_q    <= ov_d;
            oapp_q  <= oapp_d;
            osize_q <= osize_d;
            odata_q <= odata_d;
            last_q  <= last_d;
            ep_q    <= ep_d;
            ec_q    <= ec_d;
            ea_q    <= ea_d;
        end
    end

    assign out_valid = ov_q;
    assign out_app   = oapp_q;
    assign out_size  = osize_q;
    assign out_data  = odata_q;
    assign err_pulse = ep_q;
    assign err_code  = ec_q;
    assign err_app   = ea_q;

endmodule
